ryu_action_controller: RTL and testbench
========================================

// Module: ryu_action_controller
// PURPOSE
// Per-frame action sequencer for the Ryu character. Turns player key inputs and a hit event into the 3-bit
// sprite select and the RyuX/RyuY position that feed the Ryu sprite mux and renderer. Owns the timing of
// punches, jump arcs, walking, crouching and death. Updates once per video frame.
// PARAMETERS
// X_INIT        100   RyuX after reset/restart
// Y_GROUND      300   RyuY when on ground (top-left of sprite)
// X_MIN         0     left clamp for RyuX
// X_MAX         560   right clamp for RyuX (screen width minus sprite width)
// WALK_STEP     2     pixels moved per frame while walking or drifting in air
// PUNCH_FRAMES  12    frames the punch sprite is held
// JUMP_V0       12    initial upward velocity, pixels/frame
// GRAVITY       1     velocity decrement per frame
// PORTS
// vga_clk     in   1   pixel clock; all state in this domain
// reset_n     in   1   asynchronous active-low reset
// frame_tick  in   1   1-cycle pulse per frame (vga_clk domain); all state changes only on this pulse
// key_left    in   1   level, move left
// key_right   in   1   level, move right
// key_up      in   1   level, jump
// key_down    in   1   level, crouch
// key_punch   in   1   level; a punch is triggered on a rising edge sampled at frame ticks
// hit         in   1   level; Ryu takes a lethal hit
// restart     in   1   level; leave DEATH
// sprite      out  3   0 stand, 1 punch, 2 jump, 3 crouch, 4 walk left, 5 walk right, 6 death
// RyuX        out  10  sprite X position, registered
// RyuY        out  10  sprite Y position, registered
// busy        out  1   1 while in PUNCH or JUMP (ground keys are ignored)
// dead        out  1   1 while in DEATH
// BEHAVIOUR
// - Reset: state=STAND, sprite=0, RyuX=X_INIT, RyuY=Y_GROUND, vy=0, punch counter=0, punch_prev=0, busy=0, dead=0.
// - sprite, busy and dead decode directly from the state register. All outputs are registered.
// - Latency: a key change is reflected on outputs the cycle after the frame_tick that samples it.
// - punch_prev<=key_punch on every frame_tick. Punch edge = key_punch & ~punch_prev.
// - Ground states (STAND, WALK_L, WALK_R, CROUCH): on frame_tick the next state is the first match in this order:
//   hit->DEATH; punch edge->PUNCH; key_up->JUMP; key_down->CROUCH; left&~right->WALK_L; right&~left->WALK_R;
//   else STAND. Left and right together give STAND.
// - Walking moves X by WALK_STEP on the same tick the walk state is selected.
// - X is saturated to [X_MIN,X_MAX]. Use an 11-bit intermediate so X can never wrap.
// - PUNCH: entering it loads cnt=PUNCH_FRAMES-1, and each tick decrements cnt. On a tick with cnt==0 the state is
//   re-evaluated with the ground priority, so sprite 1 is shown for exactly PUNCH_FRAMES ticks.
//   No movement during a punch. hit still wins: PUNCH->DEATH.
// - JUMP: entering it loads vy=JUMP_V0 (signed, 6+ bits). Each tick: y_next=RyuY-vy (11-bit signed); vy<=vy-GRAVITY.
//   If vy<=0 and y_next>=Y_GROUND: RyuY<=Y_GROUND, state<=STAND, vy<=0 (landing tick). Otherwise RyuY<=y_next.
//   Left/right drift X by WALK_STEP with the clamp applied; both pressed means no drift. Punch/up/down are ignored.
// - DEATH from any non-death state on hit at frame_tick: RyuY snaps to Y_GROUND, RyuX holds, vy=0.
//   DEATH is terminal. All keys and hit are ignored. restart at frame_tick reloads the reset values (state STAND).
// - hit and restart on the same tick: DEATH->STAND (restart wins). In any other state, hit wins.
// - frame_tick low: all registers hold regardless of inputs.
// - reset_n low at any time (mid-jump, mid-punch) clears immediately without a clock edge.
// TESTING
// 1 Release reset -> sprite=0, RyuX=100, RyuY=300, busy=0, dead=0; inputs without frame_tick -> no change.
// 2 Hold key_right for 10 ticks -> sprite=5, RyuX=120. Set X=558 and hold 3 ticks -> RyuX=560. Left+right -> sprite=0.
// 3 Hold key_punch for 30 ticks -> sprite=1 for exactly 12 ticks, then 0. No second punch until release and re-press.
// 4 Pulse key_up 1 tick -> sprite=2, busy=1. RyuY=288 at tick 1, 222 at tick 13, 300 with sprite=0 at tick 25.
// 5 Assert hit at jump tick 5 -> sprite=6, RyuY=300, dead=1; keys ignored for 20 ticks; restart -> sprite=0, RyuX=100.
// 6 Drop reset_n between clocks at punch tick 6 -> outputs return to reset values asynchronously; next punch works.

Source files
------------

// File: rtl/ryu_action_controller.sv
// Ryu action sequencer: frame-paced state machine that turns keys and hits
// into a sprite select plus a registered sprite position.
module ryu_action_controller #(
  parameter int X_INIT       = 100,
  parameter int Y_GROUND     = 300,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 560,
  parameter int WALK_STEP    = 2,
  parameter int PUNCH_FRAMES = 12,
  parameter int JUMP_V0      = 12,
  parameter int GRAVITY      = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_punch,
  input  logic       hit,
  input  logic       restart,
  output logic [2:0] sprite,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic       busy,
  output logic       dead
);

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_PUNCH  = 3'd1,
    ST_JUMP   = 3'd2,
    ST_CROUCH = 3'd3,
    ST_WALK_L = 3'd4,
    ST_WALK_R = 3'd5,
    ST_DEATH  = 3'd6
  } state_t;

  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] STEP_S = 11'(WALK_STEP);
  localparam logic signed [10:0] YGND_S = 11'(Y_GROUND);
  localparam logic signed [6:0]  V0_S   = 7'(JUMP_V0);
  localparam logic signed [6:0]  GRAV_S = 7'(GRAVITY);
  localparam logic [5:0]         CNT_LD = 6'(PUNCH_FRAMES - 1);
  localparam logic [9:0]         X_RST  = 10'(X_INIT);
  localparam logic [9:0]         Y_RST  = 10'(Y_GROUND);

  state_t             state_q, state_d, gnd;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic signed [6:0]  vy_q, vy_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               pprev_q, pprev_d;

  logic               punch_edge, go_left, go_right;
  logic signed [10:0] x_ext, xl_raw, xr_raw, y_next;
  logic [9:0]         x_left, x_right, x_drift;
  logic               landing;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STAND;
      x_q     <= X_RST;
      y_q     <= Y_RST;
      vy_q    <= '0;
      cnt_q   <= '0;
      pprev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      cnt_q   <= cnt_d;
      pprev_q <= pprev_d;
    end
  end

  // 11-bit signed intermediates keep the clamp free of wraparound
  always_comb begin
    punch_edge = key_punch & ~pprev_q;
    go_left    = key_left & ~key_right;
    go_right   = key_right & ~key_left;
    x_ext      = signed'({1'b0, x_q});
    xl_raw     = x_ext - STEP_S;
    xr_raw     = x_ext + STEP_S;
    x_left     = (xl_raw < XMIN_S) ? XMIN_S[9:0] : xl_raw[9:0];
    x_right    = (xr_raw > XMAX_S) ? XMAX_S[9:0] : xr_raw[9:0];
    x_drift    = go_left ? x_left : (go_right ? x_right : x_q);
    y_next     = signed'({1'b0, y_q}) - {{4{vy_q[6]}}, vy_q};
    landing    = (vy_q <= 7'sd0) && (y_next >= YGND_S);
  end

  always_comb begin
    gnd = ST_STAND;
    if (hit)             gnd = ST_DEATH;
    else if (punch_edge) gnd = ST_PUNCH;
    else if (key_up)     gnd = ST_JUMP;
    else if (key_down)   gnd = ST_CROUCH;
    else if (go_left)    gnd = ST_WALK_L;
    else if (go_right)   gnd = ST_WALK_R;
  end

  always_comb begin
    logic ground_go;
    ground_go = 1'b0;
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    vy_d      = vy_q;
    cnt_d     = cnt_q;
    pprev_d   = pprev_q;
    if (frame_tick) begin
      pprev_d = key_punch;
      case (state_q)
        ST_DEATH: begin
          if (restart) begin
            state_d = ST_STAND;
            x_d     = X_RST;
            y_d     = Y_RST;
            vy_d    = '0;
            cnt_d   = '0;
          end
        end
        ST_JUMP: begin
          if (hit) begin
            state_d = ST_DEATH;
            y_d     = Y_RST;
            vy_d    = '0;
          end else begin
            x_d = x_drift;
            if (landing) begin
              state_d = ST_STAND;
              y_d     = Y_RST;
              vy_d    = '0;
            end else begin
              y_d  = y_next[9:0];
              vy_d = vy_q - GRAV_S;
            end
          end
        end
        ST_PUNCH: begin
          if (hit) ground_go = 1'b1;
          else if (cnt_q != '0) cnt_d = cnt_q - 6'd1;
          else ground_go = 1'b1;
        end
        default: ground_go = 1'b1;
      endcase
      if (ground_go) begin
        state_d = gnd;
        unique case (gnd)
          ST_PUNCH:  cnt_d = CNT_LD;
          ST_JUMP:   vy_d  = V0_S;
          ST_WALK_L: x_d   = x_left;
          ST_WALK_R: x_d   = x_right;
          ST_DEATH: begin
            y_d  = Y_RST;
            vy_d = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    sprite = state_q;
    busy   = (state_q == ST_PUNCH) || (state_q == ST_JUMP);
    dead   = (state_q == ST_DEATH);
    RyuX   = x_q;
    RyuY   = y_q;
  end

endmodule

// File: tb/tb_ryu_action_controller.sv
// Scoreboard bench for ryu_action_controller: directed scenarios plus
// randomized frames, checked against a frame-level behavioural model.
module tb_ryu_action_controller;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0;
  logic       key_down = 1'b0, key_punch = 1'b0, hit = 1'b0;
  logic       restart = 1'b0;
  logic [2:0] sprite;
  logic [9:0] RyuX, RyuY;
  logic       busy, dead;

  always #5 vga_clk = ~vga_clk;

  ryu_action_controller dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .key_left  (key_left),
    .key_right (key_right),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_punch (key_punch),
    .hit       (hit),
    .restart   (restart),
    .sprite    (sprite),
    .RyuX      (RyuX),
    .RyuY      (RyuY),
    .busy      (busy),
    .dead      (dead)
  );

  localparam logic [6:0] K_L  = 7'b1000000;
  localparam logic [6:0] K_R  = 7'b0100000;
  localparam logic [6:0] K_U  = 7'b0010000;
  localparam logic [6:0] K_D  = 7'b0001000;
  localparam logic [6:0] K_P  = 7'b0000100;
  localparam logic [6:0] K_H  = 7'b0000010;
  localparam logic [6:0] K_RS = 7'b0000001;

  typedef struct {
    string      nm;
    logic [2:0] sp;
    logic [9:0] x;
    logic [9:0] y;
    logic       b;
    logic       d;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    chk = 1'b0;
  string cur = "reset";

  // Frame-level model: mode holds the sprite code Ryu is showing
  int m_mode, m_x, m_y, m_vy, m_cnt;
  bit m_prev;

  task automatic model_reset();
    m_mode = 0; m_x = 100; m_y = 300; m_vy = 0; m_cnt = 0; m_prev = 0;
  endtask

  task automatic model_tick(input logic [6:0] k);
    bit l, r, u, d, p, h, rs, edge_p;
    int yn, vold;
    {l, r, u, d, p, h, rs} = k;
    edge_p = p && !m_prev;
    m_prev = p;
    if (m_mode == 6) begin
      if (rs) begin
        m_mode = 0; m_x = 100; m_y = 300; m_vy = 0; m_cnt = 0;
      end
      return;
    end
    if (h) begin
      m_mode = 6; m_y = 300; m_vy = 0;
      return;
    end
    if (m_mode == 2) begin
      yn = m_y - m_vy;
      vold = m_vy;
      m_vy = m_vy - 1;
      if (vold <= 0 && yn >= 300) begin
        m_mode = 0; m_y = 300; m_vy = 0;
      end else m_y = yn;
      if (l && !r) m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
      if (r && !l) m_x = (m_x + 2 > 560) ? 560 : m_x + 2;
      return;
    end
    if (m_mode == 1 && m_cnt > 0) begin
      m_cnt--;
      return;
    end
    if (edge_p) begin
      m_mode = 1; m_cnt = 11;
    end else if (u) begin
      m_mode = 2; m_vy = 12;
    end else if (d) m_mode = 3;
    else if (l && !r) begin
      m_mode = 4; m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
    end else if (r && !l) begin
      m_mode = 5; m_x = (m_x + 2 > 560) ? 560 : m_x + 2;
    end else m_mode = 0;
  endtask

  function automatic exp_t model_exp(input string nm);
    exp_t e;
    e.nm = nm;
    e.sp = 3'(m_mode);
    e.x  = 10'(m_x);
    e.y  = 10'(m_y);
    e.b  = (m_mode == 1) || (m_mode == 2);
    e.d  = (m_mode == 6);
    return e;
  endfunction

  task automatic compare(input exp_t e);
    n_checks++;
    if (sprite !== e.sp || RyuX !== e.x || RyuY !== e.y ||
        busy !== e.b || dead !== e.d) begin
      n_errors++;
      $display("FAIL %s: got sprite=%0d x=%0d y=%0d busy=%b dead=%b, expected sprite=%0d x=%0d y=%0d busy=%b dead=%b",
               e.nm, sprite, RyuX, RyuY, busy, dead, e.sp, e.x, e.y, e.b, e.d);
    end
  endtask

  // Monitor: one response per driven cycle, sampled at the falling edge
  initial forever begin
    @(posedge vga_clk);
    if (chk) begin
      @(negedge vga_clk);
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else compare(sb.pop_front());
    end
  end

  task automatic drive(input bit tk, input logic [6:0] k);
    @(posedge vga_clk);
    #1;
    {key_left, key_right, key_up, key_down, key_punch, hit, restart} = k;
    frame_tick = tk;
    chk = 1'b1;
    if (tk) model_tick(k);
    sb.push_back(model_exp(cur));
  endtask

  task automatic frames(input int n, input logic [6:0] k);
    for (int i = 0; i < n; i++) drive(1'b1, k);
  endtask

  task automatic do_reset(input string nm);
    @(posedge vga_clk);
    #1;
    chk = 1'b0;
    frame_tick = 1'b0;
    @(posedge vga_clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare(model_exp(nm));
    {key_left, key_right, key_up, key_down, key_punch, hit, restart} = '0;
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of run, expected finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    reset_n = 1'b1;

    cur = "reset_state";
    drive(1'b0, '0);
    cur = "no_tick_hold";
    drive(1'b0, K_R | K_P);
    drive(1'b0, K_U | K_H);
    drive(1'b0, K_L | K_D);

    cur = "walk_right";
    frames(10, K_R);
    cur = "walk_right_clamp";
    frames(222, K_R);
    cur = "left_and_right";
    frames(2, K_L | K_R);

    cur = "punch_hold";
    frames(30, K_P);
    cur = "punch_release";
    frames(2, '0);
    cur = "punch_repress";
    frames(14, K_P);
    frames(2, '0);

    cur = "jump_arc";
    frames(1, K_U);
    frames(30, '0);

    cur = "jump_hit";
    frames(1, K_U);
    frames(4, '0);
    frames(1, K_H);
    cur = "death_ignore";
    for (int i = 0; i < 20; i++)
      frames(1, 7'($urandom) & ~K_RS);
    cur = "restart";
    frames(1, K_RS | K_H);
    frames(2, '0);

    cur = "punch_reset";
    frames(6, K_P);
    do_reset("async_reset");
    cur = "punch_after_reset";
    frames(3, K_P);
    frames(14, '0);

    cur = "crouch";
    frames(3, K_D | K_L);

    cur = "random";
    for (int i = 0; i < 2500; i++) begin
      logic [6:0] k;
      k = '0;
      if ($urandom_range(2) == 0) k |= K_L;
      if ($urandom_range(2) == 0) k |= K_R;
      if ($urandom_range(5) == 0) k |= K_U;
      if ($urandom_range(4) == 0) k |= K_D;
      if ($urandom_range(2) == 0) k |= K_P;
      if ($urandom_range(60) == 0) k |= K_H;
      if ($urandom_range(3) == 0) k |= K_RS;
      drive($urandom_range(3) != 0, k);
    end

    @(posedge vga_clk);
    #1;
    chk = 1'b0;
    frame_tick = 1'b0;
    repeat (3) @(posedge vga_clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
